// File: rtl/regfile_ctrl.sv
// Command sequencer for an 8 x 16-bit register file: runs LOAD/MOVE/ADD/READ
// over the file's single read port and single write port, one command at a time.
module regfile_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs,
  input  logic [2:0]  cmd_rt,
  input  logic [15:0] cmd_imm,
  output logic [15:0] rf_data_in,
  output logic [2:0]  rf_writenum,
  output logic        rf_write,
  output logic [2:0]  rf_readnum,
  input  logic [15:0] rf_data_out,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf,
  output logic [2:0]  state_dbg
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [2:0] {IDLE, RDA, RDB, WB, DONE} state_t;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE outside reset.
  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [2:0]  rd_q, rs_q, rt_q;
  logic [15:0] imm_q, a_q, b_q;
  logic [15:0] sum, wb_val;
  logic        wb_ovf;
  logic        accept;

  assign cmd_ready = (state == IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign state_dbg = state;
  assign sum       = a_q + b_q;

  always_comb begin
    wb_val = a_q;
    wb_ovf = 1'b0;
    case (op_q)
      OP_LOAD: wb_val = imm_q;
      OP_ADD: begin
        wb_val = sum;
        wb_ovf = (a_q[15] == b_q[15]) & (sum[15] != a_q[15]);
      end
      default: wb_val = a_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rf_write    = 1'b0;
    rf_writenum = 3'd0;
    rf_data_in  = 16'd0;
    rf_readnum  = 3'd0;
    done        = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_op == OP_LOAD) ? WB : RDA;
      RDA: begin
        rf_readnum = rs_q;
        case (op_q)
          OP_ADD:  state_nxt = RDB;
          OP_READ: state_nxt = DONE;
          default: state_nxt = WB;
        endcase
      end
      RDB: begin
        rf_readnum = rt_q;
        state_nxt  = WB;
      end
      WB: begin
        rf_write    = 1'b1;
        rf_writenum = rd_q;
        rf_data_in  = wb_val;
        state_nxt   = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured in RDA/RDB before WB, so overlapping rd/rs/rt is safe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_LOAD;
      rd_q   <= 3'd0;
      rs_q   <= 3'd0;
      rt_q   <= 3'd0;
      imm_q  <= 16'd0;
      a_q    <= 16'd0;
      b_q    <= 16'd0;
      result <= 16'd0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= cmd_op;
          rd_q  <= cmd_rd;
          rs_q  <= cmd_rs;
          rt_q  <= cmd_rt;
          imm_q <= cmd_imm;
        end
        RDA: begin
          a_q <= rf_data_out;
          if (op_q == OP_READ) begin
            result <= rf_data_out;
            ovf    <= 1'b0;
          end
        end
        RDB: b_q <= rf_data_out;
        WB: begin
          result <= wb_val;
          ovf    <= wb_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule
